shift_mult_unit: RTL
====================

SHIFT_MULT_UNIT -- requirements
Module: shift_mult_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Run  input  1  level start request; sampled in IDLE and DONE only.
REQ-005 Ld_B  input  1  load multiplier D into B (IDLE/DONE only).
REQ-006 Clr_A  input  1  clear A and X (IDLE/DONE only).
REQ-007 D  input  WIDTH  operand bus: multiplier for Ld_B, multiplicand S at start.
REQ-008 A_out  output  WIDTH  upper product half / accumulator.
REQ-009 B_out  output  WIDTH  lower product half / multiplier shift register.
REQ-010 X_out  output  1  sign-extension bit above A.
REQ-011 busy  output  1  high in ADD and SHIFT states.
REQ-012 done  output  1  high in DONE state.

Function
REQ-013 Signed two's-complement multiply: final {A,B} equals S*B(at start) as a 2*WIDTH-bit product; X equals its sign bit.
REQ-014 FSM states: IDLE, ADD, SHIFT, DONE; bit counter cnt, width clog2(WIDTH)+1.
REQ-015 IDLE: Run=1 -> ADD next cycle; register S<=D, A<=0, X<=0, cnt<=0 on that edge.
REQ-016 ADD: if B[0]=1 and cnt<WIDTH-1, {X,A}<= sext(A)+sext(S) (WIDTH+1-bit sum); if B[0]=1 and cnt=WIDTH-1, {X,A}<= sext(A)-sext(S); if B[0]=0, A and X hold; always -> SHIFT.
REQ-017 SHIFT: {X,A,B}<= arithmetic right shift by one (X keeps value, A[W-1]<=X, B[W-1]<=A[0]); cnt<=cnt+1; -> ADD if cnt+1<WIDTH, else DONE.
REQ-018 Latency: exactly 2*WIDTH cycles spent in ADD/SHIFT; done rises on the edge 2*WIDTH+1 cycles after Run is sampled in IDLE.
REQ-019 DONE: outputs hold; Run=0 -> IDLE; Run held high keeps DONE (no re-start until Run drops).
REQ-020 Ld_B and Clr_A in IDLE/DONE act on the next edge; both set: both act; with Run in IDLE: Run start wins for A/X clear, Ld_B still loads B.
REQ-021 Ld_B, Clr_A and changes of D ignored while busy; S is the only multiplicand source during operation.
REQ-022 Overflow: none possible; sext sums are WIDTH+1 bits, no wrap lost into X.
REQ-023 Operand -2^(WIDTH-1) times -2^(WIDTH-1) yields +2^(2*WIDTH-2) correctly.

Reset
REQ-024 Reset asserted at any time, including mid-operation, immediately forces state IDLE, A=0, B=0, X=0, S=0, cnt=0, busy=0, done=0.
REQ-025 After Reset deasserts, first Run sampled high starts a fresh operation; no residual state carried.

Structure
REQ-026 Shared package mult_pkg holds the state enum type and the default WIDTH constant.
REQ-027 One sub-module shift_reg_n (parameter WIDTH: parallel load, clear, serial-in right shift, shift_out) instantiated for A and B; X, S, cnt and FSM live in shift_mult_unit.
REQ-028 All state elements in one clock domain with asynchronous Reset; adder/subtractor purely combinational.

Verification (WIDTH=8)
REQ-029 Ld_B D=0x07, Run with D=0xC5 -> after 17 cycles done=1, A=0xFE, B=0x63, X=1 (-413).
REQ-030 B=0x80, S=0x80 -> A=0x40, B=0x00, X=0 (+16384); B=0x7F, S=0x7F -> A=0x3F, B=0x01, X=0.
REQ-031 B=0x00, S=0xFF -> A=0x00, B=0x00, X=0; busy high exactly 16 cycles.
REQ-032 Run held high through DONE -> stays DONE, outputs stable; Run low -> IDLE next cycle; Ld_B/Clr_A pulsed while busy -> product unchanged.
REQ-033 Reset asserted asynchronously at cycle 5 of an operation -> all outputs 0 before next edge; subsequent run of 0x07 x 0xC5 gives 0xFE63.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed shift-and-add multiplier.
package mult_pkg;

    // Default operand width used when the top is instantiated without override.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: ADD and SHIFT alternate once per multiplier bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the bit counter; one extra bit so it can reach WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_reg_n.sv
// Parallel-load right-shift register with synchronous clear and serial input.
// Priority: clear over load over shift. shift_out presents the current LSB,
// i.e. the bit that leaves the register on the next shift.
module shift_reg_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             shift_out
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-value selection: clear, parallel load, or shift right with serial_in at the MSB.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (shift) begin
            q_d = {serial_in, q_q[WIDTH-1:1]};
        end
    end

    // Register with asynchronous reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign shift_out = q_q[0];

endmodule

// File: rtl/shift_mult_unit.sv
// Sequential signed (two's-complement) multiplier.
// {X,A,B} forms a 2*WIDTH+1 bit accumulator: A collects partial sums, B holds
// the multiplier and receives product bits as they shift out of A. The last
// multiplier bit carries negative weight, so its partial product is subtracted.
module shift_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Ld_B,
    input  logic             Clr_A,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             X_out,
    output logic             busy,
    output logic             done
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_END  = CNT_W'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    // Control strobes into the A and B shift registers.
    logic               a_clr, a_load, a_shift;
    logic [WIDTH-1:0]   a_load_val;
    logic               b_load, b_shift;
    logic [WIDTH-1:0]   a_val, b_val;
    logic               a_lsb, b_lsb;

    // Sign-extended add/subtract; the extra bit absorbs any carry so nothing wraps.
    logic [WIDTH:0]     a_ext, s_ext, addsub;

    shift_reg_n #(.WIDTH(WIDTH)) u_a_reg (
        .clk       (Clk),
        .rst       (Reset),
        .clr       (a_clr),
        .load      (a_load),
        .shift     (a_shift),
        .serial_in (x_q),
        .d         (a_load_val),
        .q         (a_val),
        .shift_out (a_lsb)
    );

    shift_reg_n #(.WIDTH(WIDTH)) u_b_reg (
        .clk       (Clk),
        .rst       (Reset),
        .clr       (1'b0),
        .load      (b_load),
        .shift     (b_shift),
        .serial_in (a_lsb),
        .d         (D),
        .q         (b_val),
        .shift_out (b_lsb)
    );

    // Partial-product adder: subtract on the sign-weighted final multiplier bit.
    always_comb begin
        a_ext  = {a_val[WIDTH-1], a_val};
        s_ext  = {s_q[WIDTH-1], s_q};
        addsub = (cnt_q == CNT_LAST) ? (a_ext - s_ext) : (a_ext + s_ext);
    end

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and datapath control for the IDLE/ADD/SHIFT/DONE sequence.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        x_d        = x_q;
        cnt_d      = cnt_q;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_shift    = 1'b0;
        a_load_val = addsub[WIDTH-1:0];
        b_load     = 1'b0;
        b_shift    = 1'b0;

        unique case (state_q)
            IDLE: begin
                b_load = Ld_B;
                if (Run) begin
                    // Start: capture multiplicand and zero the accumulator.
                    s_d     = D;
                    a_clr   = 1'b1;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end else if (Clr_A) begin
                    a_clr = 1'b1;
                    x_d   = 1'b0;
                end
            end
            ADD: begin
                if (b_lsb) begin
                    a_load = 1'b1;
                    x_d    = addsub[WIDTH];
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                // X is replicated into A's MSB and stays put (arithmetic shift).
                a_shift = 1'b1;
                b_shift = 1'b1;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc < CNT_END) ? ADD : DONE;
            end
            DONE: begin
                b_load = Ld_B;
                if (Clr_A) begin
                    a_clr = 1'b1;
                    x_d   = 1'b0;
                end
                // A held Run keeps the result; a new start needs Run to drop first.
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and multiplicand/sign/counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A_out = a_val;
    assign B_out = b_val;
    assign X_out = x_q;
    assign busy  = (state_q == ADD) || (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule
